fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types: instruction bus request/response, fetch output,
// the issue-FSM state encoding and the queue entry layout.
package fetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer: power-of-two depth, wrapping pointers plus an
// explicit occupancy count, synchronous flush on redirect.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fq_entry_t     din,
    output fq_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; only pointers and count define which slots hold data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding bus request FSM, redirect
// handling with stale-response dropping, and a registered fetch output.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic [63:0] jump,
    input  logic        stop,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output fetch_data_t dataF
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state, state_next;
    logic [63:0]   pc, pc_next, pc_inc;
    logic [63:0]   addr, addr_next;
    logic          push, pop, full, empty;
    logic [CW-1:0] count, count_after;
    fq_entry_t     head, push_entry;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (branch),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign pop         = !stop && !branch && !empty;
    assign count_after = count + CW'(1) - CW'(pop);
    assign pc_inc      = pc + INSTR_BYTES;
    assign push_entry  = '{pc: addr, instr: iresp.data};
    assign ireq.valid  = (state != IDLE);
    assign ireq.addr   = addr;

    // NOTE: combinational next-state logic uses blocking assignments with every output defaulted first, so no latch can form.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = addr;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                if (branch) begin
                    pc_next    = jump;
                    addr_next  = jump;
                    state_next = REQ;
                end else if (!full) begin
                    addr_next  = pc;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (branch) begin
                    pc_next = jump;
                    if (iresp.data_ok) begin
                        addr_next  = jump;
                        state_next = REQ;
                    end else begin
                        state_next = DROP;
                    end
                end else if (iresp.data_ok) begin
                    push       = 1'b1;
                    pc_next    = pc_inc;
                    addr_next  = pc_inc;
                    state_next = (count_after < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                // The in-flight address stays on the bus until its response is swallowed.
                if (branch) pc_next = jump;
                if (iresp.data_ok) begin
                    addr_next  = branch ? jump : pc;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            addr  <= addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataF <= '0;
        end else if (branch) begin
            dataF.valid <= 1'b0;
        end else if (!stop) begin
            dataF.valid <= !empty;
            if (!empty) begin
                dataF.instr <= head.instr;
                dataF.pc    <= head.pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a table of per-cycle vectors for start-up,
// streaming and stall/drain, then hand-written redirect and reset sequences.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch;
    logic [63:0] jump;
    logic        stop;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    fetch_data_t dataF;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .branch (branch),
        .jump   (jump),
        .stop   (stop),
        .ireq   (ireq),
        .iresp  (iresp),
        .dataF  (dataF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stp;
        logic        ok;
        logic [31:0] data;
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic [63:0] dpc;
        logic [31:0] di;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic stp, input logic ok, input logic [31:0] data,
                                input logic iv, input logic [63:0] ia,
                                input logic dv, input logic [63:0] dpc, input logic [31:0] di);
        vec_t v;
        v.stp = stp; v.ok = ok; v.data = data;
        v.iv = iv; v.ia = ia; v.dv = dv; v.dpc = dpc; v.di = di;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic br, input logic [63:0] jmp,
                         input logic stp, input logic ok, input logic [31:0] data);
        reset         = rst;
        branch        = br;
        jump          = jmp;
        stop          = stp;
        iresp.data_ok = ok;
        iresp.data    = data;
    endtask

    task automatic expect_out(input string tag, input logic iv, input logic [63:0] ia,
                              input logic dv, input logic [63:0] dpc, input logic [31:0] di,
                              input logic chk_data);
        check({tag, " ireq.valid"}, 64'(ireq.valid), 64'(iv));
        if (iv) check({tag, " ireq.addr"}, ireq.addr, ia);
        check({tag, " dataF.valid"}, 64'(dataF.valid), 64'(dv));
        if (chk_data) begin
            check({tag, " dataF.pc"}, dataF.pc, dpc);
            check({tag, " dataF.instr"}, 64'(dataF.instr), 64'(di));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Start-up stream, stall for ten cycles with data_ok every cycle, then drain.
        vecs.push_back(mk(0, 1, 32'hDEAD_0000, 0, 64'h0,         0, 64'h0,         32'h0));
        vecs.push_back(mk(0, 1, 32'h11,        1, 64'h8000_0000, 0, 64'h0,         32'h0));
        vecs.push_back(mk(0, 1, 32'h22,        1, 64'h8000_0004, 0, 64'h0,         32'h0));
        vecs.push_back(mk(0, 1, 32'h33,        1, 64'h8000_0008, 1, 64'h8000_0000, 32'h11));
        vecs.push_back(mk(0, 0, 32'h0,         1, 64'h8000_000C, 1, 64'h8000_0004, 32'h22));
        vecs.push_back(mk(1, 1, 32'h44,        1, 64'h8000_000C, 1, 64'h8000_0008, 32'h33));
        vecs.push_back(mk(1, 1, 32'h55,        1, 64'h8000_0010, 1, 64'h8000_0008, 32'h33));
        vecs.push_back(mk(1, 1, 32'h66,        1, 64'h8000_0014, 1, 64'h8000_0008, 32'h33));
        vecs.push_back(mk(1, 1, 32'h77,        1, 64'h8000_0018, 1, 64'h8000_0008, 32'h33));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 1, 32'h88,    0, 64'h0,         1, 64'h8000_0008, 32'h33));
        vecs.push_back(mk(0, 0, 32'h0,         0, 64'h0,         1, 64'h8000_0008, 32'h33));
        vecs.push_back(mk(0, 0, 32'h0,         0, 64'h0,         1, 64'h8000_000C, 32'h44));
        vecs.push_back(mk(0, 0, 32'h0,         1, 64'h8000_001C, 1, 64'h8000_0010, 32'h55));
        vecs.push_back(mk(0, 1, 32'h99,        1, 64'h8000_001C, 1, 64'h8000_0014, 32'h66));
        vecs.push_back(mk(0, 0, 32'h0,         1, 64'h8000_0020, 1, 64'h8000_0018, 32'h77));
        vecs.push_back(mk(0, 0, 32'h0,         1, 64'h8000_0020, 1, 64'h8000_001C, 32'h99));
        vecs.push_back(mk(0, 0, 32'h0,         1, 64'h8000_0020, 0, 64'h8000_001C, 32'h99));

        // Reset must override branch, stop and data_ok.
        drive(1, 1, 64'h1234, 1, 1, 32'hBAD0);
        tick();
        tick();
        expect_out("reset", 0, 64'h0, 0, 64'h0, 32'h0, 1);

        foreach (vecs[i]) begin
            drive(0, 0, 64'h0, vecs[i].stp, vecs[i].ok, vecs[i].data);
            expect_out($sformatf("vec%0d", i), vecs[i].iv, vecs[i].ia,
                       vecs[i].dv, vecs[i].dpc, vecs[i].di, 1);
            tick();
        end

        // Redirect while a request waits: in-flight address holds, its response is dropped.
        drive(0, 1, 64'h8000_1000, 0, 0, 32'h0);
        expect_out("drop0", 1, 64'h8000_0020, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("drop1", 1, 64'h8000_0020, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 1, 32'hBAD1);
        expect_out("drop2", 1, 64'h8000_0020, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("drop3", 1, 64'h8000_1000, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 1, 32'hC1);
        expect_out("drop4", 1, 64'h8000_1000, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("drop5", 1, 64'h8000_1004, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 1, 0, 32'h0);
        expect_out("drop6", 1, 64'h8000_1004, 1, 64'h8000_1000, 32'hC1, 1);

        // Branch together with data_ok under stall, with one entry queued: everything flushed.
        drive(0, 0, 64'h0, 1, 1, 32'hC2);
        tick();
        drive(0, 1, 64'h8000_2000, 1, 1, 32'hC3);
        expect_out("flush0", 1, 64'h8000_1008, 1, 64'h8000_1000, 32'hC1, 1);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("flush1", 1, 64'h8000_2000, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 1, 32'hC4);
        expect_out("flush2", 1, 64'h8000_2000, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("flush3", 1, 64'h8000_2004, 0, 64'h0, 32'h0, 0);
        tick();
        expect_out("flush4", 1, 64'h8000_2004, 1, 64'h8000_2000, 32'hC4, 1);
        tick();

        // Reset while in DROP, with a data_ok in the first cycle afterwards.
        drive(0, 1, 64'h8000_3000, 0, 0, 32'h0);
        tick();
        drive(1, 1, 64'h8000_4000, 1, 1, 32'hBAD2);
        expect_out("rstdrop0", 1, 64'h8000_2004, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 1, 32'hBAD3);
        expect_out("rstdrop1", 0, 64'h0, 0, 64'h0, 32'h0, 1);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("rstdrop2", 1, 64'h8000_0000, 0, 64'h0, 32'h0, 0);
        tick();

        // Branch from IDLE to the top of the address space; pc+4 wraps to zero.
        drive(1, 0, 64'h0, 0, 0, 32'h0);
        tick();
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'h0);
        expect_out("wrap0", 0, 64'h0, 0, 64'h0, 32'h0, 1);
        tick();
        drive(0, 0, 64'h0, 0, 1, 32'hE1);
        expect_out("wrap1", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0, 0, 32'h0);
        expect_out("wrap2", 1, 64'h0, 0, 64'h0, 32'h0, 0);
        tick();
        expect_out("wrap3", 1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hE1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
